ram_bank_arbiter: RTL and testbench
===================================

# ram_bank_arbiter

Shares a set of single-port RAM banks between multiple requesters. Each requester issues one word read or write per handshake to a flat address space. Addresses are low-order interleaved across the banks, and each bank has its own round-robin arbiter, so requests to different banks proceed in parallel while same-bank conflicts are serialized fairly. Read data returns one cycle after the grant, routed back to the issuing requester. The block sits between the requester-facing stream logic and the array of `ram_sp` banks.

## Interface
- `RAM_WIDTH`, 8: data width of each bank.
- `RAM_DEPTH`, 256: words per bank; power of two.
- `N_REQUESTORS`, 2: number of requesters; at least 2.
- `N_BANKS`, 2: number of banks; power of two, at least 2.
- Derived: `BANK_BW = $clog2(N_BANKS)`, `ROW_BW = $clog2(RAM_DEPTH)`, `ADDR_BW = ROW_BW + BANK_BW`.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  [N_REQUESTORS]  request present.
- `req_wen`  in  [N_REQUESTORS]  1 = write, 0 = read.
- `req_addr`  in  [N_REQUESTORS][ADDR_BW]  flat word address.
- `req_wdata`  in  [N_REQUESTORS][RAM_WIDTH]  write data.
- `req_ready`  out  [N_REQUESTORS]  request granted this cycle.
- `rsp_valid`  out  [N_REQUESTORS]  read data valid.
- `rsp_data`  out  [N_REQUESTORS][RAM_WIDTH]  read data.
- `ram_cen`  out  [N_BANKS]  bank enable, active high.
- `ram_wen`  out  [N_BANKS]  bank write enable, active high.
- `ram_addr`  out  [N_BANKS][ROW_BW]  bank row address.
- `ram_din`  out  [N_BANKS][RAM_WIDTH]  bank write data.
- `ram_dout`  in  [N_BANKS][RAM_WIDTH]  bank read data, valid the cycle after the enabled read.

## Operation
- Address decode:
  - bank = `req_addr[BANK_BW-1:0]`
  - row = `req_addr[ADDR_BW-1:BANK_BW]`
- Per bank b:
  - Candidates are requesters with `req_valid` set and decoded bank equal to b.
  - The winner is the first candidate at or after `rr_ptr[b]`, searching upward with wrap from N_REQUESTORS-1 to 0.
- On a grant to requester r for bank b:
  - `req_ready[r]=1`, `ram_cen[b]=1`.
  - `ram_wen[b]=req_wen[r]`, `ram_addr[b]=row`, `ram_din[b]=req_wdata[r]`.
  - `rr_ptr[b]` is set to (r+1) mod N_REQUESTORS.
- A bank with no candidate drives `cen=0`, `wen=0`, and zero address and data. Its `rr_ptr` holds.
- At most one grant per requester per cycle (one address per requester), and at most one per bank.
- Requester handshake rule: once `req_valid` is asserted, `req_valid`, `req_wen`, `req_addr` and `req_wdata` stay stable until `req_ready`. A requester may present back-to-back requests.
- Read return tracking:
  - A granted read registers a tag per requester: pending valid plus bank index.
  - In the next cycle, `rsp_valid[r]=1` and `rsp_data[r]=ram_dout[tag_bank[r]]`.
  - There is no response backpressure; the requester must accept.
- Writes produce no response. A read and a write to the same row in different cycles are ordered by grant order.

## Timing
- Request-to-grant path is combinational: `req_ready` and the `ram_*` outputs are combinational from `req_*`, `rr_ptr` and `rst`.
- Read latency: grant in cycle t, `rsp_valid` in cycle t+1.
- Full throughput is one access per bank per cycle. Same-bank contention with all N requesters active gives each requester one grant every N cycles.
- Reset values, while `rst` is asserted:
  - `rr_ptr` = 0, all tags invalid, `rsp_valid` = 0.
  - `req_ready` and `ram_cen` are forced to 0.
- Reset mid-operation: any in-flight read response is discarded, so no `rsp_valid` appears in the cycle after reset deassertion.
- Simultaneous events: a requester can receive `rsp_valid` for its previous read in the same cycle it is granted a new read.

## Structure
- `ram_ctrl_pkg` holds:
  - the `bank_idx_t`, `row_addr_t` and `req_addr_t` typedefs;
  - a function `bank_of(addr)`;
  - the derived width constants.
- Sub-module `rr_arbiter` (inputs `req[N]` and `ptr`; outputs one-hot `gnt` and `gnt_idx`) is instantiated once per bank in a generate loop. Pointer state stays in the parent.

## Test plan
All scenarios use the default parameters.
- Reset: with `rst` high and `req_valid=2'b11`, `req_ready=0`, `ram_cen=0` and `rsp_valid=0`. After release, `rr_ptr` is 0.
- No conflict: R0 reads addr 0x004 (bank 0, row 2), R1 writes 0x5A to 0x007 (bank 1, row 3), same cycle.
  - Both are ready.
  - `ram_cen=2'b11`, `ram_addr[0]=2`, `ram_addr[1]=3`, `ram_wen[1]=1`.
  - `rsp_valid[0]` is set the next cycle.
- Conflict fairness: both requesters read bank 0 continuously for 6 cycles.
  - Grants alternate R0, R1, R0, R1, R0, R1.
  - Each read is followed one cycle later by a response on the matching requester.
- Write then read back: R0 writes 0xA5 to 0x011, then reads 0x011.
  - `rsp_data[0]=0xA5` one cycle after the read grant.
- Stall stability: R1 loses to R0 on bank 1.
  - R1 holds its request, is granted the next cycle, and its `ram_addr` matches the held value.
- Reset mid-read: assert `rst` in the cycle after a read grant.
  - No `rsp_valid` appears.
  - The first grant after reset goes to the lowest-index requester.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared types, default sizes and address-decode helpers for the RAM bank arbiter.
// Holds the default bank geometry, derived address widths, the bank/row/address
// typedefs and bank_of()/row_of() for splitting a flat word address.
package ram_ctrl_pkg;

  localparam int unsigned DEF_RAM_WIDTH    = 8;
  localparam int unsigned DEF_RAM_DEPTH    = 256;
  localparam int unsigned DEF_N_REQUESTORS = 2;
  localparam int unsigned DEF_N_BANKS      = 2;

  localparam int unsigned BANK_BW = $clog2(DEF_N_BANKS);
  localparam int unsigned ROW_BW  = $clog2(DEF_RAM_DEPTH);
  localparam int unsigned ADDR_BW = ROW_BW + BANK_BW;

  typedef logic [BANK_BW-1:0] bank_idx_t;
  typedef logic [ROW_BW-1:0]  row_addr_t;
  typedef logic [ADDR_BW-1:0] req_addr_t;

  // Low-order interleave: the bottom address bits select the bank.
  function automatic bank_idx_t bank_of(input req_addr_t addr);
    return addr[BANK_BW-1:0];
  endfunction

  function automatic row_addr_t row_of(input req_addr_t addr);
    return addr[ADDR_BW-1:BANK_BW];
  endfunction

endpackage

// File: rtl/ram_bank_arbiter_if.sv
// Requester-facing bus of the RAM bank arbiter.
// master: requester side (drives req_*, receives req_ready and rsp_*).
// slave : arbiter side.
interface ram_bank_arbiter_if
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ  = DEF_N_REQUESTORS,
  parameter int unsigned ADDR_W = ADDR_BW,
  parameter int unsigned DATA_W = DEF_RAM_WIDTH
);

  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0]             req_wen;
  logic [N_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0][DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]             req_ready;
  logic [N_REQ-1:0]             rsp_valid;
  logic [N_REQ-1:0][DATA_W-1:0] rsp_data;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
// Ports: req (request vector), ptr (search start), gnt (one-hot grant),
//        gnt_idx (index of the granted requester, 0 when none).
module rr_arbiter #(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic          found;
  logic [IW-1:0] cur;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cur     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cur = IW'((32'(ptr) + k) % N);
      if (!found && req[cur]) begin
        found      = 1'b1;
        gnt[cur]   = 1'b1;
        gnt_idx    = cur;
      end
    end
  end

endmodule

// File: rtl/ram_bank_arbiter.sv
// Shares interleaved single-port RAM banks between several requesters.
// Ports: clk, rst (async, active high); bus (requester handshake + read
//        response, slave side); ram_cen/ram_wen/ram_addr/ram_din per bank
//        toward the RAMs; ram_dout per bank, valid the cycle after a read.
// Grant and RAM-side outputs are combinational; read responses come from
// per-requester tags registered at grant time.
module ram_bank_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter  int unsigned RAM_WIDTH    = DEF_RAM_WIDTH,
  parameter  int unsigned RAM_DEPTH    = DEF_RAM_DEPTH,
  parameter  int unsigned N_REQUESTORS = DEF_N_REQUESTORS,
  parameter  int unsigned N_BANKS      = DEF_N_BANKS,
  localparam int unsigned BANK_W       = $clog2(N_BANKS),
  localparam int unsigned ROW_W        = $clog2(RAM_DEPTH),
  localparam int unsigned ADDR_W       = ROW_W + BANK_W,
  localparam int unsigned REQ_IW       = $clog2(N_REQUESTORS)
) (
  input  logic                              clk,
  input  logic                              rst,
  ram_bank_arbiter_if.slave                 bus,
  output logic [N_BANKS-1:0]                ram_cen,
  output logic [N_BANKS-1:0]                ram_wen,
  output logic [N_BANKS-1:0][ROW_W-1:0]     ram_addr,
  output logic [N_BANKS-1:0][RAM_WIDTH-1:0] ram_din,
  input  logic [N_BANKS-1:0][RAM_WIDTH-1:0] ram_dout
);

  logic [N_REQUESTORS-1:0][BANK_W-1:0]  req_bank;
  logic [N_REQUESTORS-1:0][ROW_W-1:0]   req_row;
  logic [N_BANKS-1:0][N_REQUESTORS-1:0] cand;
  logic [N_BANKS-1:0][N_REQUESTORS-1:0] gnt;
  logic [N_BANKS-1:0][REQ_IW-1:0]       gnt_idx;
  logic [N_BANKS-1:0]                   bank_act;
  logic [N_BANKS-1:0][REQ_IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [N_REQUESTORS-1:0]              ready_c;
  logic [N_REQUESTORS-1:0]              tag_vld_q, tag_vld_d;
  logic [N_REQUESTORS-1:0][BANK_W-1:0]  tag_bank_q, tag_bank_d;

  // Address decode and per-bank candidate sets.
  always_comb begin
    req_bank = '0;
    req_row  = '0;
    cand     = '0;
    for (int unsigned r = 0; r < N_REQUESTORS; r++) begin
      req_bank[r] = bus.req_addr[r][BANK_W-1:0];
      req_row[r]  = bus.req_addr[r][ADDR_W-1:BANK_W];
    end
    for (int unsigned b = 0; b < N_BANKS; b++) begin
      for (int unsigned r = 0; r < N_REQUESTORS; r++) begin
        cand[b][r] = bus.req_valid[r] && (req_bank[r] == BANK_W'(b));
      end
    end
  end

  // One arbiter per bank; pointer state lives here.
  for (genvar gb = 0; gb < N_BANKS; gb++) begin : g_bank
    rr_arbiter #(
      .N (N_REQUESTORS)
    ) u_arb (
      .req     (cand[gb]),
      .ptr     (rr_ptr_q[gb]),
      .gnt     (gnt[gb]),
      .gnt_idx (gnt_idx[gb])
    );
  end

  // Grant fan-out to requesters and bank ports; reset blocks all grants.
  always_comb begin
    ready_c  = '0;
    bank_act = '0;
    ram_cen  = '0;
    ram_wen  = '0;
    ram_addr = '0;
    ram_din  = '0;
    for (int unsigned b = 0; b < N_BANKS; b++) begin
      if (!rst && (|gnt[b])) begin
        bank_act[b] = 1'b1;
        ready_c     = ready_c | gnt[b];
        ram_cen[b]  = 1'b1;
        ram_wen[b]  = bus.req_wen[gnt_idx[b]];
        ram_addr[b] = req_row[gnt_idx[b]];
        ram_din[b]  = bus.req_wdata[gnt_idx[b]];
      end
    end
  end

  assign bus.req_ready = ready_c;

  // Pointer advance past the winner; read tags for next-cycle return.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    tag_vld_d  = '0;
    tag_bank_d = '0;
    for (int unsigned b = 0; b < N_BANKS; b++) begin
      if (bank_act[b]) begin
        rr_ptr_d[b] = (gnt_idx[b] == REQ_IW'(N_REQUESTORS - 1)) ? '0 : gnt_idx[b] + 1'b1;
      end
    end
    for (int unsigned r = 0; r < N_REQUESTORS; r++) begin
      tag_vld_d[r]  = ready_c[r] && !bus.req_wen[r];
      tag_bank_d[r] = req_bank[r];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      tag_vld_q  <= '0;
      tag_bank_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      tag_vld_q  <= tag_vld_d;
      tag_bank_q <= tag_bank_d;
    end
  end

  // Route the tagged bank's read data back to the requester.
  always_comb begin
    bus.rsp_valid = tag_vld_q;
    bus.rsp_data  = '0;
    for (int unsigned r = 0; r < N_REQUESTORS; r++) begin
      if (tag_vld_q[r]) begin
        bus.rsp_data[r] = ram_dout[tag_bank_q[r]];
      end
    end
  end

endmodule

// File: tb/tb_ram_bank_arbiter.sv
// Directed scoreboard bench for ram_bank_arbiter with a behavioural RAM model.
module tb_ram_bank_arbiter;
  import ram_ctrl_pkg::*;

  localparam int unsigned NR = DEF_N_REQUESTORS;
  localparam int unsigned NB = DEF_N_BANKS;
  localparam int unsigned DW = DEF_RAM_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_bank_arbiter_if #(.N_REQ(NR), .ADDR_W(ADDR_BW), .DATA_W(DW)) bus ();

  logic [NB-1:0]                ram_cen;
  logic [NB-1:0]                ram_wen;
  logic [NB-1:0][ROW_BW-1:0]    ram_addr;
  logic [NB-1:0][DW-1:0]        ram_din;
  logic [NB-1:0][DW-1:0]        ram_dout;

  ram_bank_arbiter #(
    .RAM_WIDTH    (DW),
    .RAM_DEPTH    (DEF_RAM_DEPTH),
    .N_REQUESTORS (NR),
    .N_BANKS      (NB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ram_cen  (ram_cen),
    .ram_wen  (ram_wen),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  // Single-port RAM banks; preloaded so each word holds its flat address low byte.
  logic [DW-1:0] mem [NB][DEF_RAM_DEPTH];
  always @(posedge clk) begin
    for (int b = 0; b < int'(NB); b++) begin
      if (ram_cen[b]) begin
        if (ram_wen[b]) mem[b][ram_addr[b]] = ram_din[b];
        else            ram_dout[b] <= mem[b][ram_addr[b]];
      end
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int unsigned cyc;
    logic        wen;
    bank_idx_t   bank;
    row_addr_t   row;
    logic [DW-1:0] din;
  } gnt_exp_t;

  typedef struct {
    int unsigned   cyc;
    logic [DW-1:0] data;
  } rsp_exp_t;

  gnt_exp_t gq [NR][$];
  rsp_exp_t rq [NR][$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s: event not matched by scoreboard (cycle %0d)", name, cyc);
  endtask

  task automatic drive(input int r, input logic v, input logic w,
                       input req_addr_t a, input logic [DW-1:0] d);
    bus.req_valid[r] = v;
    bus.req_wen[r]   = w;
    bus.req_addr[r]  = a;
    bus.req_wdata[r] = d;
  endtask

  task automatic idle_all();
    for (int r = 0; r < int'(NR); r++) drive(r, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic exp_gnt(input int r, input logic w, input req_addr_t a, input logic [DW-1:0] d);
    gnt_exp_t e;
    e.cyc  = cyc;
    e.wen  = w;
    e.bank = bank_of(a);
    e.row  = row_of(a);
    e.din  = d;
    gq[r].push_back(e);
  endtask

  task automatic exp_rsp(input int r, input logic [DW-1:0] data);
    rsp_exp_t e;
    e.cyc  = cyc + 1;
    e.data = data;
    rq[r].push_back(e);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every grant and every response must match the scoreboard front.
  always @(negedge clk) begin : mon
    gnt_exp_t ge;
    rsp_exp_t re;
    for (int r = 0; r < int'(NR); r++) begin
      if (bus.req_ready[r] === 1'b1) begin
        if (gq[r].size() == 0) flag($sformatf("gnt_unexpected_r%0d", r));
        else begin
          ge = gq[r].pop_front();
          chk($sformatf("gnt_cycle_r%0d", r), 32'(cyc), 32'(ge.cyc));
          chk($sformatf("gnt_bankport_r%0d", r),
              32'({ram_cen[ge.bank], ram_wen[ge.bank], ram_addr[ge.bank], ram_din[ge.bank]}),
              32'({1'b1, ge.wen, ge.row, ge.din}));
        end
      end else if (gq[r].size() != 0 && gq[r][0].cyc <= cyc) begin
        void'(gq[r].pop_front());
        flag($sformatf("gnt_missing_r%0d", r));
      end
      if (bus.rsp_valid[r] === 1'b1) begin
        if (rq[r].size() == 0) flag($sformatf("rsp_unexpected_r%0d", r));
        else begin
          re = rq[r].pop_front();
          chk($sformatf("rsp_cycle_r%0d", r), 32'(cyc), 32'(re.cyc));
          chk($sformatf("rsp_data_r%0d", r), 32'(bus.rsp_data[r]), 32'(re.data));
        end
      end else if (rq[r].size() != 0 && rq[r][0].cyc <= cyc) begin
        void'(rq[r].pop_front());
        flag($sformatf("rsp_missing_r%0d", r));
      end
    end
  end

  initial begin
    for (int b = 0; b < int'(NB); b++)
      for (int row = 0; row < int'(DEF_RAM_DEPTH); row++)
        mem[b][row] = DW'(row * int'(NB) + b);

    // Reset with both requesters asking for bank 0.
    idle_all();
    rst = 1'b1;
    drive(0, 1'b1, 1'b0, 9'h002, 8'h00);
    drive(1, 1'b1, 1'b0, 9'h006, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_cen",   32'(ram_cen),       32'h0);
    chk("rst_rsp",   32'(bus.rsp_valid), 32'h0);

    // Same-bank contention: R0 first (pointer cleared), then strict alternation.
    next();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) next();
      if (k % 2 == 0) begin
        exp_gnt(0, 1'b0, 9'h002, 8'h00);
        exp_rsp(0, 8'h02);
      end else begin
        exp_gnt(1, 1'b0, 9'h006, 8'h00);
        exp_rsp(1, 8'h06);
      end
    end
    next();
    idle_all();
    @(negedge clk);
    chk("idle_cen_wen",   32'({ram_cen, ram_wen}), 32'h0);
    chk("idle_addr_din",  32'({ram_addr, ram_din}), 32'h0);

    // Different banks in parallel: R0 reads bank 0 row 2, R1 writes bank 1 row 3.
    next();
    drive(0, 1'b1, 1'b0, 9'h004, 8'h00);
    drive(1, 1'b1, 1'b1, 9'h007, 8'h5A);
    exp_gnt(0, 1'b0, 9'h004, 8'h00);
    exp_gnt(1, 1'b1, 9'h007, 8'h5A);
    exp_rsp(0, 8'h04);
    @(negedge clk);
    chk("nc_cen",  32'(ram_cen), 32'h3);
    chk("nc_addr", 32'({ram_addr[1], ram_addr[0]}), 32'h0302);
    chk("nc_wen",  32'(ram_wen), 32'h2);
    next();
    idle_all();

    // Write then read back through the same requester.
    next();
    drive(0, 1'b1, 1'b1, 9'h011, 8'hA5);
    exp_gnt(0, 1'b1, 9'h011, 8'hA5);
    next();
    drive(0, 1'b1, 1'b0, 9'h011, 8'h00);
    exp_gnt(0, 1'b0, 9'h011, 8'h00);
    exp_rsp(0, 8'hA5);
    next();
    idle_all();

    // R1 reads the earlier write; this also hands bank 1's pointer back to R0.
    next();
    drive(1, 1'b1, 1'b0, 9'h007, 8'h00);
    exp_gnt(1, 1'b0, 9'h007, 8'h00);
    exp_rsp(1, 8'h5A);

    // Stall: R1 loses bank 1 to R0 and must hold its request.
    next();
    drive(0, 1'b1, 1'b0, 9'h003, 8'h00);
    drive(1, 1'b1, 1'b0, 9'h00D, 8'h00);
    exp_gnt(0, 1'b0, 9'h003, 8'h00);
    exp_rsp(0, 8'h03);
    @(negedge clk);
    chk("stall_r1_wait", 32'(bus.req_ready[1]), 32'h0);
    next();
    drive(0, 1'b1, 1'b0, 9'h008, 8'h00);
    exp_gnt(0, 1'b0, 9'h008, 8'h00);
    exp_rsp(0, 8'h08);
    exp_gnt(1, 1'b0, 9'h00D, 8'h00);
    exp_rsp(1, 8'h0D);
    @(negedge clk);
    chk("stall_r1_addr", 32'(ram_addr[1]), 32'h6);
    chk("rsp_with_new_gnt_r0", 32'({bus.rsp_valid[0], bus.req_ready[0]}), 32'h3);
    next();
    idle_all();

    // Reset right after a read grant: the response is dropped.
    next();
    drive(0, 1'b1, 1'b0, 9'h00C, 8'h00);
    exp_gnt(0, 1'b0, 9'h00C, 8'h00);
    next();
    rst = 1'b1;
    drive(0, 1'b1, 1'b0, 9'h010, 8'h00);
    drive(1, 1'b1, 1'b0, 9'h01E, 8'h00);
    @(negedge clk);
    chk("midrst_rsp",   32'(bus.rsp_valid), 32'h0);
    chk("midrst_ready", 32'(bus.req_ready), 32'h0);
    next();
    rst = 1'b0;
    exp_gnt(0, 1'b0, 9'h010, 8'h00);
    exp_rsp(0, 8'h10);
    @(negedge clk);
    chk("postrst_rsp", 32'(bus.rsp_valid), 32'h0);
    next();
    drive(0, 1'b0, 1'b0, '0, '0);
    exp_gnt(1, 1'b0, 9'h01E, 8'h00);
    exp_rsp(1, 8'h1E);
    next();
    idle_all();
    repeat (3) next();

    for (int r = 0; r < int'(NR); r++) begin
      chk($sformatf("gq_drained_r%0d", r), 32'(gq[r].size()), 32'h0);
      chk($sformatf("rq_drained_r%0d", r), 32'(rq[r].size()), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
